segmentation_v2: RTL and testbench
==================================

# segmentation_v2

Parametrised second-generation DAC segmentation block. It splits each signed input sample into a coarse MSB code and a fine LSB code. The truncation residue is noise-shaped with selectable first- or second-order error feedback, so the analog sum of the two sub-DACs reproduces the input. It sits between the digital modulator and the coarse/fine unit-element DAC drivers. The block adds coarse-code saturation, a saturation event counter, registered offset outputs and a valid strobe.

## Interface
- IN_W, 5: input sample width (signed).
- F, 1: number of fine LSBs removed from the coarse path (F ≥ 1).
- CO_W, 4: signed coarse code width before offset.
- C_OFS, 9: offset added to the coarse code.
- F_OFS, 3: offset added to the fine code.
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  sample enable; all state advances only when high.
- order_sel  in  1  0 = first-order shaping, 1 = second-order shaping.
- in_i  in  IN_W  signed input sample.
- coarse_o  out  CO_W+2  coarse code plus C_OFS, unsigned.
- fine_o  out  F+3  fine code plus F_OFS, unsigned.
- valid_o  out  1  coarse_o/fine_o updated with primed data this cycle.
- sat_o  out  1  coarse code clipped for the sample now on the outputs.
- sat_cnt_o  out  8  saturation event count; saturates at 255.

## Operation
- State registers:
  - a_d: delayed input.
  - r1, r2: residue history, F bits, unsigned.
  - ord_q: latched order_sel.
  - primed.
- Combinational datapath, evaluated from registers, with internal width IN_W+3:
  - Order 1: v = a_d + r1.
  - Order 2: v = a_d + 2·r1 − r2.
  - c_raw = v >>> F (floor).
  - Clip c_raw to [−2^(CO_W−1), 2^(CO_W−1)−1] to give c_sat; sat = (c_raw ≠ c_sat).
  - r_new = v[F−1:0].
  - fine = (c_sat << F) − a_d, clipped to the signed F+2-bit range.
- On an enabled edge (clk_en=1, rst=0):
  - a_d ← in_i.
  - r2 ← r1; r1 ← r_new.
  - primed ← 1.
  - coarse_o ← c_sat + C_OFS, fine_o ← fine + F_OFS, sat_o ← sat.
  - sat_cnt_o increments if sat is set and the count is below 255.
- Saturation: when sat=1, r1 and r2 are cleared instead of shifted, so no error is integrated through a clipped code.
- Mode change: ord_q ← order_sel on every enabled edge. If order_sel ≠ ord_q, r1 and r2 are cleared on that edge and the new order applies from the next sample. Saturation clearing and mode-change clearing coincide harmlessly.
- clk_en=0: all registers hold; valid_o ← 0.
- Output wrap: offset addition wraps modulo the output width. With default parameters the result is always in range (coarse 1..16, fine 1..5).

## Timing
- Reset values (rst high at a clock edge; rst takes priority over clk_en):
  - a_d = r1 = r2 = 0, ord_q = 0, primed = 0.
  - coarse_o = C_OFS, fine_o = F_OFS.
  - valid_o = 0, sat_o = 0, sat_cnt_o = 0.
- Latency: a sample taken at enabled edge k appears on coarse_o/fine_o after enabled edge k+1, i.e. two enabled edges.
- valid_o ← clk_en & primed. The first enabled edge after reset produces valid_o=0; valid_o is high in the cycle after each later enabled edge.
- Reset asserted mid-stream clears all history immediately; the first post-reset output again has valid_o=0.
- In the default order-1 configuration, behaviour matches the existing first-order segmentation with offsets 9/3: same recurrence, same coarse/fine codes.

## Test plan
- Reset: hold rst 3 cycles with clk_en=1 and in_i=7 -> coarse_o=9, fine_o=3, valid_o=0, sat_cnt_o=0 throughout.
- Order 1, constant in_i=3, clk_en=1 -> outputs alternate (coarse_o,fine_o) = (10,2), (11,4), … starting from the second enabled edge; valid_o=1 from the second post-reset edge.
- clk_en gating: same stimulus as the order-1 test, with clk_en toggled 1/0 -> outputs change only after enabled edges, the sequence is unchanged, and valid_o=0 in every cycle after a disabled edge.
- Order 2, constant in_i=15 -> v alternates 15/17. coarse_o stays at 16 (7+9) and fine_o stays at 2. sat_o=1 on every second output; sat_cnt_o counts 1, 2, …, and holds at 255 after 510 samples.
- Mode switch: run order 1 with in_i=3, then set order_sel=1 on an enabled edge -> r1/r2 are cleared on that edge. The next output uses v=a_d=3 (coarse_o=10, fine_o=2), with no stale residue.
- Reset mid-stream: assert rst during the order-2 saturation run -> next cycle shows coarse_o=9, fine_o=3, sat_cnt_o=0; the sequence restarts identically to the post-reset order-1 run.

Source files
------------

// File: rtl/segmentation_v2.sv
// DAC segmentation: splits a signed sample into coarse MSB and fine LSB codes,
// noise-shaping the truncation residue with first- or second-order error feedback.
module segmentation_v2 #(
  parameter int IN_W  = 5,
  parameter int F     = 1,
  parameter int CO_W  = 4,
  parameter int C_OFS = 9,
  parameter int F_OFS = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              order_sel,
  input  logic [IN_W-1:0]   in_i,
  output logic [CO_W+1:0]   coarse_o,
  output logic [F+2:0]      fine_o,
  output logic              valid_o,
  output logic              sat_o,
  output logic [7:0]        sat_cnt_o
);
  localparam int W = IN_W + 3;
  localparam logic signed [W-1:0] C_MAX = W'((1 << (CO_W - 1)) - 1);
  localparam logic signed [W-1:0] C_MIN = -C_MAX - W'(1);
  localparam logic signed [W-1:0] FN_MAX = W'((1 << (F + 1)) - 1);
  localparam logic signed [W-1:0] FN_MIN = -FN_MAX - W'(1);

  logic signed [IN_W-1:0] a_d;
  logic [F-1:0]           r1, r2;
  logic                   ord_q;
  logic                   primed;

  logic signed [W-1:0] a_ext, r1_ext, r2_ext, v, c_raw, c_sat_w, fine_full;
  logic signed [CO_W-1:0] c_sat;
  logic signed [F+1:0]    fine_c;
  logic                   sat;
  logic [F-1:0]           r_new;
  logic                   clr;
  logic [CO_W+1:0]        coarse_nxt;
  logic [F+2:0]           fine_nxt;

  always_comb begin
    a_ext  = W'(a_d);
    r1_ext = {{(W-F){1'b0}}, r1};
    r2_ext = {{(W-F){1'b0}}, r2};
    if (ord_q) v = a_ext + (r1_ext <<< 1) - r2_ext;
    else       v = a_ext + r1_ext;
    c_raw = v >>> F;
    if (c_raw > C_MAX)      c_sat_w = C_MAX;
    else if (c_raw < C_MIN) c_sat_w = C_MIN;
    else                    c_sat_w = c_raw;
    sat    = (c_raw != c_sat_w);
    c_sat  = c_sat_w[CO_W-1:0];
    r_new  = v[F-1:0];
    fine_full = (c_sat_w <<< F) - a_ext;
    if (fine_full > FN_MAX)      fine_c = FN_MAX[F+1:0];
    else if (fine_full < FN_MIN) fine_c = FN_MIN[F+1:0];
    else                         fine_c = fine_full[F+1:0];
    // Offsets wrap modulo the output width.
    coarse_nxt = {{2{c_sat[CO_W-1]}}, c_sat} + (CO_W+2)'(C_OFS);
    fine_nxt   = {fine_c[F+1], fine_c} + (F+3)'(F_OFS);
    // A clipped code or an order change drops the residue history.
    clr = sat | (order_sel != ord_q);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      a_d       <= '0;
      r1        <= '0;
      r2        <= '0;
      ord_q     <= 1'b0;
      primed    <= 1'b0;
      coarse_o  <= (CO_W+2)'(C_OFS);
      fine_o    <= (F+3)'(F_OFS);
      valid_o   <= 1'b0;
      sat_o     <= 1'b0;
      sat_cnt_o <= '0;
    end else if (clk_en) begin
      a_d      <= in_i;
      r2       <= clr ? '0 : r1;
      r1       <= clr ? '0 : r_new;
      ord_q    <= order_sel;
      primed   <= 1'b1;
      coarse_o <= coarse_nxt;
      fine_o   <= fine_nxt;
      valid_o  <= primed;
      sat_o    <= sat;
      if (sat && sat_cnt_o != 8'hFF) sat_cnt_o <= sat_cnt_o + 8'd1;
    end else begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_segmentation_v2.sv
// Bench for segmentation_v2: hand-computed vector table plus a scoreboard
// fed by an integer reference model of the segmentation recurrence.
module tb_segmentation_v2;
  localparam int IN_W = 5, F = 1, CO_W = 4, C_OFS = 9, F_OFS = 3;

  logic             clock = 1'b0;
  logic             rst = 1'b1, clk_en = 1'b0, order_sel = 1'b0;
  logic [IN_W-1:0]  in_i = '0;
  logic [CO_W+1:0]  coarse_o;
  logic [F+2:0]     fine_o;
  logic             valid_o, sat_o;
  logic [7:0]       sat_cnt_o;

  segmentation_v2 #(.IN_W(IN_W), .F(F), .CO_W(CO_W), .C_OFS(C_OFS), .F_OFS(F_OFS)) dut (
    .clock(clock), .rst(rst), .clk_en(clk_en), .order_sel(order_sel), .in_i(in_i),
    .coarse_o(coarse_o), .fine_o(fine_o), .valid_o(valid_o), .sat_o(sat_o),
    .sat_cnt_o(sat_cnt_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed expectation: {coarse[5:0], fine[3:0], valid, sat, cnt[7:0]}.
  logic [19:0] exp_q[$];

  int m_ad, m_r1, m_r2, m_ord, m_primed, m_cnt;
  int m_coarse, m_fine, m_valid, m_sat;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic o, input logic [IN_W-1:0] x);
    int v, c_raw, c_sat, fn, rn, s, clr, q;
    q = 1 << F;
    if (r) begin
      m_ad = 0; m_r1 = 0; m_r2 = 0; m_ord = 0; m_primed = 0; m_cnt = 0;
      m_coarse = C_OFS; m_fine = F_OFS; m_valid = 0; m_sat = 0;
    end else if (e) begin
      v = (m_ord != 0) ? m_ad + 2 * m_r1 - m_r2 : m_ad + m_r1;
      c_raw = floor_div(v, q);
      c_sat = c_raw;
      if (c_sat > (1 << (CO_W - 1)) - 1) c_sat = (1 << (CO_W - 1)) - 1;
      if (c_sat < -(1 << (CO_W - 1)))    c_sat = -(1 << (CO_W - 1));
      s  = (c_sat != c_raw) ? 1 : 0;
      rn = v - c_raw * q;
      fn = c_sat * q - m_ad;
      if (fn > (1 << (F + 1)) - 1) fn = (1 << (F + 1)) - 1;
      if (fn < -(1 << (F + 1)))    fn = -(1 << (F + 1));
      m_coarse = (c_sat + C_OFS) & ((1 << (CO_W + 2)) - 1);
      m_fine   = (fn + F_OFS) & ((1 << (F + 3)) - 1);
      m_valid  = m_primed;
      m_sat    = s;
      if (s != 0 && m_cnt < 255) m_cnt++;
      clr  = (s != 0 || int'(o) != m_ord) ? 1 : 0;
      m_r2 = (clr != 0) ? 0 : m_r1;
      m_r1 = (clr != 0) ? 0 : rn;
      m_ad = int'($signed(x));
      m_ord = int'(o);
      m_primed = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic sb_check();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check("sb_queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("sb_coarse", int'(coarse_o), int'(e[19:14]));
    check("sb_fine",   int'(fine_o),   int'(e[13:10]));
    check("sb_valid",  int'(valid_o),  int'(e[9]));
    check("sb_sat",    int'(sat_o),    int'(e[8]));
    check("sb_cnt",    int'(sat_cnt_o), int'(e[7:0]));
  endtask

  // Drive one cycle, predict, then sample 1 ns after the edge.
  task automatic step(input logic r, input logic e, input logic o, input logic [IN_W-1:0] x);
    rst = r; clk_en = e; order_sel = o; in_i = x;
    model_step(r, e, o, x);
    exp_q.push_back({6'(m_coarse), 4'(m_fine), 1'(m_valid), 1'(m_sat), 8'(m_cnt)});
    @(posedge clock);
    #1;
    sb_check();
  endtask

  typedef struct {
    logic en;
    logic ord;
    logic [IN_W-1:0] in;
    int c, f, v, s;
  } vec_t;
  vec_t tbl[11];

  task automatic run_vec(input int i);
    step(1'b0, tbl[i].en, tbl[i].ord, tbl[i].in);
    check($sformatf("vec%0d_coarse", i), int'(coarse_o), tbl[i].c);
    check($sformatf("vec%0d_fine", i),   int'(fine_o),   tbl[i].f);
    check($sformatf("vec%0d_valid", i),  int'(valid_o),  tbl[i].v);
    check($sformatf("vec%0d_sat", i),    int'(sat_o),    tbl[i].s);
  endtask

  initial begin
    // Order 1, in=3, gating, then a switch to order 2 while r1=1.
    tbl[0]  = '{1'b1, 1'b0, 5'd3,  9, 3, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 5'd3, 10, 2, 1, 0};
    tbl[2]  = '{1'b1, 1'b0, 5'd3, 11, 4, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 5'd3, 11, 4, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 5'd3, 10, 2, 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 5'd3, 10, 2, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 5'd3, 11, 4, 1, 0};
    tbl[7]  = '{1'b1, 1'b0, 5'd3, 10, 2, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 5'd3, 11, 4, 1, 0};
    tbl[9]  = '{1'b1, 1'b1, 5'd3, 10, 2, 1, 0};
    tbl[10] = '{1'b1, 1'b1, 5'd3, 11, 4, 1, 0};

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'd7);
      check("rst_coarse", int'(coarse_o), 9);
      check("rst_fine",   int'(fine_o),   3);
      check("rst_valid",  int'(valid_o),  0);
      check("rst_cnt",    int'(sat_cnt_o), 0);
    end

    for (int i = 0; i < 11; i++) run_vec(i);

    // Order-2 saturation run, long enough for the counter to stick at 255.
    step(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 1030; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'd15);
      if (i >= 2) begin
        check("o2_coarse", int'(coarse_o), 16);
        check("o2_fine",   int'(fine_o),   2);
      end
    end
    check("o2_cnt_hold", int'(sat_cnt_o), 255);

    // Reset mid-stream, then the order-1 opening must replay exactly.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 5'd15);
    step(1'b1, 1'b1, 1'b1, 5'd15);
    check("mid_rst_coarse", int'(coarse_o), 9);
    check("mid_rst_fine",   int'(fine_o),   3);
    check("mid_rst_cnt",    int'(sat_cnt_o), 0);
    for (int i = 0; i < 3; i++) run_vec(i);

    // Random stimulus against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 60) < 30), 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
